// File: rtl/issue_stage_buffered_if.sv
// Signal bundle of issue_stage_buffered: fetch->backend requests, backend->PLB replies and status.
// The stage itself connects through the slave modport; its environment uses master.
interface issue_stage_buffered_if #(
    parameter int REQ_DATA_WIDTH  = 32,
    parameter int RSP_DATA_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                      flush_i;
    logic                      fetch_valid_i;
    logic                      fetch_ready_o;
    logic [REQ_DATA_WIDTH-1:0] fetch_data_i;
    logic                      be_req_valid_o;
    logic                      be_req_ready_i;
    logic [REQ_DATA_WIDTH-1:0] be_req_data_o;
    logic                      be_rsp_valid_i;
    logic                      be_rsp_ready_o;
    logic [RSP_DATA_WIDTH-1:0] be_rsp_data_i;
    logic                      plb_valid_o;
    logic                      plb_ready_i;
    logic [RSP_DATA_WIDTH-1:0] plb_data_o;
    logic [OUT_W-1:0]          outstanding_o;
    logic                      idle_o;
    logic [31:0]               stall_cnt_o;

    modport slave (
        input  flush_i, fetch_valid_i, fetch_data_i, be_req_ready_i,
               be_rsp_valid_i, be_rsp_data_i, plb_ready_i,
        output fetch_ready_o, be_req_valid_o, be_req_data_o, be_rsp_ready_o,
               plb_valid_o, plb_data_o, outstanding_o, idle_o, stall_cnt_o
    );

    modport master (
        output flush_i, fetch_valid_i, fetch_data_i, be_req_ready_i,
               be_rsp_valid_i, be_rsp_data_i, plb_ready_i,
        input  fetch_ready_o, be_req_valid_o, be_req_data_o, be_rsp_ready_o,
               plb_valid_o, plb_data_o, outstanding_o, idle_o, stall_cnt_o
    );
endinterface

// File: rtl/issue_stage_buffered.sv
// Credit-limited issue stage: fetch->backend and backend->PLB paths, each an optional FIFO.
// Define ISSUE_STALL_CNT_EN to build the saturating fetch stall-cycle counter.

module issue_stage_buffered_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage is not reset; an entry is only read once written, and outputs are valid-gated.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));
endmodule

module issue_stage_buffered #(
    parameter int REQ_DATA_WIDTH  = 32,
    parameter int RSP_DATA_WIDTH  = 32,
    parameter int REQ_DEPTH       = 2,
    parameter int RSP_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    issue_stage_buffered_if.slave bus
);
    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] flush_drop;
    logic             credit_ok;
    logic             fetch_hs;
    logic             plb_hs;
    logic             req_busy;
    logic             rsp_busy;

    assign credit_ok = (outstanding < OUT_MAX);
    assign fetch_hs  = bus.fetch_valid_i && bus.fetch_ready_o;
    assign plb_hs    = bus.plb_valid_o && bus.plb_ready_i;

    if (REQ_DEPTH == 0) begin : g_req_pass
        // Nothing is held on this path, so a flush only blocks it for one cycle.
        assign bus.fetch_ready_o  = bus.be_req_ready_i && credit_ok && !bus.flush_i;
        assign bus.be_req_valid_o = bus.fetch_valid_i && credit_ok && !bus.flush_i;
        assign bus.be_req_data_o  = bus.fetch_data_i;
        assign req_busy           = 1'b0;
        assign flush_drop         = '0;
    end else begin : g_req_fifo
        logic [REQ_DATA_WIDTH-1:0]      head;
        logic                           full;
        logic [$clog2(REQ_DEPTH+1)-1:0] count;

        issue_stage_buffered_fifo #(.WIDTH(REQ_DATA_WIDTH), .DEPTH(REQ_DEPTH)) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clear (bus.flush_i),
            .push  (fetch_hs),
            .pop   (bus.be_req_valid_o && bus.be_req_ready_i),
            .wdata (bus.fetch_data_i),
            .head  (head),
            .full  (full),
            .count (count)
        );

        assign bus.fetch_ready_o  = !full && credit_ok && !bus.flush_i;
        assign bus.be_req_valid_o = (count != '0) && !bus.flush_i;
        assign bus.be_req_data_o  = bus.be_req_valid_o ? head : '0;
        assign req_busy           = (count != '0);
        // Each buffered request holds one credit, so its occupancy always fits the counter.
        assign flush_drop         = bus.flush_i ? OUT_W'(count) : '0;
    end

    if (RSP_DEPTH == 0) begin : g_rsp_pass
        assign bus.be_rsp_ready_o = bus.plb_ready_i;
        assign bus.plb_valid_o    = bus.be_rsp_valid_i;
        assign bus.plb_data_o     = bus.be_rsp_data_i;
        assign rsp_busy           = 1'b0;
    end else begin : g_rsp_fifo
        logic [RSP_DATA_WIDTH-1:0]      head;
        logic                           full;
        logic [$clog2(RSP_DEPTH+1)-1:0] count;

        issue_stage_buffered_fifo #(.WIDTH(RSP_DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clear (1'b0),
            .push  (bus.be_rsp_valid_i && bus.be_rsp_ready_o),
            .pop   (plb_hs),
            .wdata (bus.be_rsp_data_i),
            .head  (head),
            .full  (full),
            .count (count)
        );

        assign bus.be_rsp_ready_o = !full;
        assign bus.plb_valid_o    = (count != '0);
        assign bus.plb_data_o     = bus.plb_valid_o ? head : '0;
        assign rsp_busy           = (count != '0);
    end

    // A fetch accept and a flush never coincide, since flush_i forces fetch_ready_o low.
    always_ff @(posedge clk_i) begin
        if (rst_i) outstanding <= '0;
        else       outstanding <= outstanding + OUT_W'(fetch_hs) - OUT_W'(plb_hs) - flush_drop;
    end

    assign bus.outstanding_o = outstanding;
    assign bus.idle_o        = (outstanding == '0) && !req_busy && !rsp_busy;

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (bus.fetch_valid_i && !bus.fetch_ready_o && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
`else
    assign bus.stall_cnt_o = '0;
`endif

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        plb_hs |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding <= OUT_MAX);
endmodule
